fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the LEGv8 fetch stage against a multi-cycle instruction memory with a req/ack handshake.
- Owns the fetch PC and issues requests to imem.
- Applies branch redirects (PCSrc_F/PCBranch_F) even when a request is outstanding, and drops stale responses.
- Presents instruction/PC/valid to the IF/ID register, honouring stall_F from downstream.

Parameters:
- N, 64, address/PC width.
- RESET_PC, 64'd0, first fetch address after reset.
- IW, 32, instruction width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- PCSrc_F  in  1  branch/redirect taken this cycle.
- PCBranch_F  in  N  redirect target.
- stall_F  in  1  IF/ID not accepting; output must hold.
- imem_req  out  1  request valid to imem.
- imem_addr_F  out  N  request address; stable while imem_req=1 and no ack.
- imem_ack  in  1  imem response valid this cycle; may be high in the same cycle as imem_req.
- imem_rdata  in  IW  instruction data, valid when imem_ack=1.
- instr_F  out  IW  fetched instruction to IF/ID.
- pc_F  out  N  address of instr_F.
- valid_F  out  1  instr_F/pc_F valid.

Behaviour:
- Reset (reset=0, async):
  - Outputs: imem_req=0, imem_addr_F=RESET_PC, instr_F=0, pc_F=0, valid_F=0.
  - Internal state: state=IDLE, skid empty, saved target=0.
  - Any request in flight is abandoned; a late ack after reset release is ignored unless imem_req=1.
- All outputs are registered.
- Handshake: a transfer completes at a posedge where imem_req=1 and imem_ack=1. imem_addr_F never changes while imem_req=1 without ack.
- Consume: at a posedge with valid_F=1 and stall_F=0, IF/ID takes the output.
- Priority per edge: reset > PCSrc_F > imem_ack > stall_F.
- Redirect (PCSrc_F=1):
  - valid_F clears next edge regardless of stall_F (flush).
  - Target is PCBranch_F with bits [1:0] forced to 0.
- Arithmetic: next sequential address = addr + 4, modulo 2^N (all-ones-minus-3 wraps to 0).
- FSM:
  - IDLE: entered only from reset. Next edge -> REQ with imem_req=1, imem_addr_F=RESET_PC.
  - REQ (imem_req=1):
    - PCSrc_F & ack: discard rdata; imem_addr_F<=target; stay REQ.
    - PCSrc_F & !ack: save target; -> DROP.
    - ack & output slot free (valid_F=0 or stall_F=0): instr_F<=rdata, pc_F<=imem_addr_F, valid_F<=1, imem_addr_F<=addr+4; stay REQ.
    - ack & valid_F=1 & stall_F=1: store rdata/addr in skid; imem_req<=0; -> HOLD.
    - No ack: hold.
  - HOLD (imem_req=0, skid full):
    - PCSrc_F: discard skid; imem_req<=1, imem_addr_F<=target; -> REQ.
    - stall_F=0: output<=skid, valid_F=1; imem_req<=1, imem_addr_F<=skid addr+4; -> REQ.
    - Else: hold.
  - DROP (imem_req=1 at the old address, stale):
    - PCSrc_F again: overwrite saved target.
    - On ack: discard rdata; imem_addr_F<=saved target (or the new PCBranch_F if PCSrc_F is also high that edge); -> REQ.
    - valid_F stays 0 throughout DROP.
- Throughput/latency:
  - Zero-wait imem (ack combinational with req): one instruction per cycle.
  - valid_F rises on the edge where ack is sampled.
  - First valid_F occurs 2 edges after reset release.
- No instruction is ever duplicated or skipped:
  - pc_F sequence increments by 4 except immediately after a redirect, where it equals the target.

Test Plan:
- Reset at 0x0, imem ack same cycle, stall_F=0 for 5 cycles -> pc_F = 0,4,8,12 on consecutive edges; valid_F=1 from 2nd edge after release.
- imem ack 3 cycles after each req -> imem_addr_F stable across wait cycles; valid_F pulses one cycle per instruction; pc_F = 0,4,8.
- PCSrc_F=1, PCBranch_F=64'd10 while a request to 0x8 is outstanding (no ack) -> DROP; ack data for 0x8 discarded; next imem_addr_F=64'd8 (10 with low bits cleared); next pc_F=8 carrying the new data; valid_F low until then.
- stall_F=1 with valid_F=1 and ack arriving -> HOLD, imem_req=0; release stall -> skid instruction appears next edge with pc_F = previous+4, fetch resumes at +8.
- PCSrc_F and ack in the same cycle in HOLD and in REQ -> stale data never reaches valid_F; imem_addr_F = target next edge.
- Assert reset mid-request with pc_F=0x40 -> all outputs return to reset values immediately; fetch restarts at RESET_PC; wrap check with RESET_PC=2^64-4 -> second fetch address 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: LEGv8 fetch-stage sequencer in front of a multi-cycle req/ack instruction memory.
// Owns the fetch PC, applies redirects even with a request in flight, and skids one word on stall.
module fetch_ctrl #(
   parameter int           N        = 64,
   parameter logic [N-1:0] RESET_PC = '0,
   parameter int           IW       = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          PCSrc_F,
   input  logic [N-1:0]  PCBranch_F,
   input  logic          stall_F,
   output logic          imem_req,
   output logic [N-1:0]  imem_addr_F,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic [IW-1:0] instr_F,
   output logic [N-1:0]  pc_F,
   output logic          valid_F,
   output logic [1:0]    dbg_state
);

   // Handshake: one imem beat transfers on a posedge where imem_req=1 and imem_ack=1;
   // while imem_req=1 and imem_ack=0 the request (imem_addr_F) is frozen.
   // Downstream takes instr_F/pc_F on a posedge where valid_F=1 and stall_F=0.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   localparam logic [N-1:0] ADDR_STEP = N'(4);

   state_t        r_state;
   logic          r_req;
   logic [N-1:0]  r_addr;
   logic [IW-1:0] r_instr;
   logic [N-1:0]  r_pc;
   logic          r_valid;
   logic [IW-1:0] r_skid_instr;
   logic [N-1:0]  r_skid_addr;
   logic [N-1:0]  r_saved_tgt;

   logic [N-1:0]  w_target;
   logic          w_slot_free;

   assign w_target    = {PCBranch_F[N-1:2], 2'b00};
   assign w_slot_free = !r_valid || !stall_F;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_req        <= 1'b0;
         r_addr       <= RESET_PC;
         r_instr      <= '0;
         r_pc         <= '0;
         r_valid      <= 1'b0;
         r_skid_instr <= '0;
         r_skid_addr  <= '0;
         r_saved_tgt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_REQ;
               r_req   <= 1'b1;
               r_addr  <= RESET_PC;
            end

            S_REQ: begin
               if (PCSrc_F) begin
                  r_valid <= 1'b0;
                  if (imem_ack) begin
                     r_addr <= w_target;
                  end else begin
                     // Request is still in flight at the old address; its data must be thrown away.
                     r_saved_tgt <= w_target;
                     r_state     <= S_DROP;
                  end
               end else if (imem_ack) begin
                  if (w_slot_free) begin
                     r_instr <= imem_rdata;
                     r_pc    <= r_addr;
                     r_valid <= 1'b1;
                     r_addr  <= r_addr + ADDR_STEP;
                  end else begin
                     r_skid_instr <= imem_rdata;
                     r_skid_addr  <= r_addr;
                     r_req        <= 1'b0;
                     r_state      <= S_HOLD;
                  end
               end else if (!stall_F) begin
                  r_valid <= 1'b0;
               end
            end

            S_HOLD: begin
               if (PCSrc_F) begin
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
                  r_addr  <= w_target;
                  r_state <= S_REQ;
               end else if (!stall_F) begin
                  r_instr <= r_skid_instr;
                  r_pc    <= r_skid_addr;
                  r_valid <= 1'b1;
                  r_req   <= 1'b1;
                  r_addr  <= r_skid_addr + ADDR_STEP;
                  r_state <= S_REQ;
               end
            end

            S_DROP: begin
               if (imem_ack) begin
                  r_addr  <= PCSrc_F ? w_target : r_saved_tgt;
                  r_state <= S_REQ;
               end else if (PCSrc_F) begin
                  r_saved_tgt <= w_target;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr_F = r_addr;
   assign instr_F     = r_instr;
   assign pc_F        = r_pc;
   assign valid_F     = r_valid;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus for fetch_ctrl with a latency-programmable imem model,
// a stream-level reference model checked every cycle, and hand-computed literal expectations.
module tb_fetch_ctrl;

   localparam int             N       = 64;
   localparam int             IW      = 32;
   localparam logic [N-1:0]   WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [IW-1:0]  POISON  = 32'hDEAD_BEEF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          pcsrc;
   logic [N-1:0]  pcbranch;
   logic          stall;

   logic          imem_req;
   logic [N-1:0]  imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_rdata;
   logic [IW-1:0] instr;
   logic [N-1:0]  pc;
   logic          valid;
   logic [1:0]    dbg;

   logic          w_req;
   logic [N-1:0]  w_addr;
   logic          w_ack;
   logic [IW-1:0] w_rdata;
   logic [IW-1:0] w_instr;
   logic [N-1:0]  w_pc;
   logic          w_valid;
   logic [1:0]    w_dbg;

   function automatic logic [IW-1:0] mem_fn(input logic [N-1:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
   endfunction

   fetch_ctrl #(.N(N), .RESET_PC(64'd0), .IW(IW)) u_dut (
      .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(pcbranch), .stall_F(stall),
      .imem_req(imem_req), .imem_addr_F(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_F(instr), .pc_F(pc), .valid_F(valid), .dbg_state(dbg)
   );

   fetch_ctrl #(.N(N), .RESET_PC(WRAP_PC), .IW(IW)) u_wrap (
      .clk(clk), .reset(reset), .PCSrc_F(1'b0), .PCBranch_F(64'd0), .stall_F(1'b0),
      .imem_req(w_req), .imem_addr_F(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
      .instr_F(w_instr), .pc_F(w_pc), .valid_F(w_valid), .dbg_state(w_dbg)
   );

   assign w_ack   = w_req;
   assign w_rdata = mem_fn(w_addr);

   // ---------------- imem model ----------------
   // Acks after `lat` waiting cycles; while a poison request is pending the returned word is junk.
   int lat;
   int cnt;
   int poison_req;
   int poison_done;

   assign imem_ack   = imem_req && (cnt >= lat);
   assign imem_rdata = (poison_req != poison_done) ? POISON : mem_fn(imem_addr);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= 0;
         poison_done <= poison_req;
      end else if (imem_req && imem_ack) begin
         cnt         <= 0;
         poison_done <= poison_req;
      end else if (imem_req) begin
         cnt <= cnt + 1;
      end else begin
         cnt <= 0;
      end
   end

   // ---------------- scoreboard bookkeeping ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // ---------------- stream-level reference model ----------------
   // exp_pc is the address of the next instruction the consumer must see: it advances by 4
   // on every consumption and jumps to the aligned target on every redirect.
   logic [N-1:0]  exp_pc;
   logic          p_have;
   logic          p_req, p_ack, p_valid, p_stall, p_pcsrc;
   logic [N-1:0]  p_addr, p_pc;
   logic [IW-1:0] p_instr;

   initial begin
      exp_pc = '0;
      p_have = 1'b0;
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("rst_req",   imem_req,  1'b0);
         check("rst_addr",  imem_addr, 64'd0);
         check("rst_instr", instr,     32'd0);
         check("rst_pc",    pc,        64'd0);
         check("rst_valid", valid,     1'b0);
         exp_pc = 64'd0;
         p_have = 1'b0;
      end else begin
         if (p_have) begin
            if (p_req && !p_ack) begin
               check("addr_stable", imem_addr, p_addr);
               check("req_held",    imem_req,  1'b1);
            end
            if (p_valid && p_stall && !p_pcsrc) begin
               check("stall_valid", valid, 1'b1);
               check("stall_pc",    pc,    p_pc);
               check("stall_instr", instr, p_instr);
            end
            if (p_pcsrc) check("flush_valid", valid, 1'b0);
         end
         if (valid) begin
            check("pc_seq",     pc,    exp_pc);
            check("instr_data", instr, mem_fn(pc));
         end
         if (valid && !stall) exp_pc = exp_pc + 64'd4;
         if (pcsrc) exp_pc = {pcbranch[N-1:2], 2'b00};
         p_req   = imem_req;
         p_ack   = imem_ack;
         p_addr  = imem_addr;
         p_valid = valid;
         p_stall = stall;
         p_pcsrc = pcsrc;
         p_pc    = pc;
         p_instr = instr;
         p_have  = 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      pcsrc    = 1'b0;
      pcbranch = '0;
      stall    = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!valid && k < 50);
      check({name, "_seen"}, valid, 1'b1);
   endtask

   task automatic redirect(input logic [N-1:0] tgt, input bit stale_in_flight);
      pcsrc    = 1'b1;
      pcbranch = tgt;
      if (stale_in_flight) poison_req++;
      step();
      pcsrc    = 1'b0;
      pcbranch = '0;
   endtask

   // ---------------- directed tests ----------------
   logic [N-1:0] t2_pcs [3];

   initial begin
      reset       = 1'b0;
      pcsrc       = 1'b0;
      pcbranch    = '0;
      stall       = 1'b0;
      lat         = 0;
      poison_req  = 0;
      t2_pcs[0]   = 64'h0;
      t2_pcs[1]   = 64'h4;
      t2_pcs[2]   = 64'h8;

      // Zero-wait imem: one instruction per cycle, first valid two edges after release.
      do_reset();
      step();
      check("t1_e1_valid", valid, 1'b0);
      check("t1_e1_req",   imem_req, 1'b1);
      check("t1_e1_addr",  imem_addr, 64'h0);
      check("wrap_e1_addr", w_addr, WRAP_PC);
      step();
      check("t1_e2_valid", valid, 1'b1);
      check("t1_e2_pc",    pc, 64'h0);
      check("t1_e2_instr", instr, 32'h5A5A_0000);
      check("wrap_e2_pc",  w_pc, WRAP_PC);
      check("wrap_e2_instr", w_instr, 32'h5A5A_0003);
      check("wrap_e2_addr", w_addr, 64'h0);
      step();
      check("t1_e3_pc", pc, 64'h4);
      check("wrap_e3_pc", w_pc, 64'h0);
      step();
      check("t1_e4_pc", pc, 64'h8);
      step();
      check("t1_e5_pc",    pc, 64'hC);
      check("t1_e5_instr", instr, 32'h5A5A_000C);

      // Slow imem: one valid pulse per instruction.
      lat = 3;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wait_valid("t2_valid");
         check("t2_pc", pc, t2_pcs[i]);
         step();
         check("t2_pulse", valid, 1'b0);
      end

      // Redirect while the request to 0x8 is outstanding: its data is dropped.
      do_reset();
      wait_valid("t3_v0");
      check("t3_pc0", pc, 64'h0);
      wait_valid("t3_v4");
      check("t3_pc4", pc, 64'h4);
      check("t3_pending_addr", imem_addr, 64'h8);
      redirect(64'd10, 1'b1);
      check("t3_drop_valid", valid, 1'b0);
      check("t3_drop_req",   imem_req, 1'b1);
      check("t3_drop_addr",  imem_addr, 64'h8);
      wait_valid("t3_vt");
      check("t3_tgt_pc",    pc, 64'h8);
      check("t3_tgt_instr", instr, 32'h5A5A_0008);
      wait_valid("t3_vn");
      check("t3_next_pc", pc, 64'hC);

      // Stall with an ack arriving: skid, then resume.
      lat = 0;
      do_reset();
      step();
      step();
      check("t4_pc0", pc, 64'h0);
      stall = 1'b1;
      step();
      check("t4_hold_req",   imem_req, 1'b0);
      check("t4_hold_valid", valid, 1'b1);
      check("t4_hold_pc",    pc, 64'h0);
      step();
      check("t4_hold2_pc",  pc, 64'h0);
      check("t4_hold2_req", imem_req, 1'b0);
      stall = 1'b0;
      step();
      check("t4_skid_pc",    pc, 64'h4);
      check("t4_skid_instr", instr, 32'h5A5A_0004);
      check("t4_resume_addr", imem_addr, 64'h8);
      check("t4_resume_req",  imem_req, 1'b1);
      step();
      check("t4_next_pc", pc, 64'h8);

      // Redirect in HOLD, then redirect in REQ coinciding with an ack.
      stall = 1'b1;
      step();
      check("t5_hold_req", imem_req, 1'b0);
      redirect(64'h100, 1'b0);
      check("t5_hold_flush", valid, 1'b0);
      check("t5_hold_addr",  imem_addr, 64'h100);
      check("t5_hold_req2",  imem_req, 1'b1);
      stall = 1'b0;
      step();
      check("t5_tgt_pc", pc, 64'h100);
      check("t5_ack_now", imem_ack, 1'b1);
      redirect(64'h203, 1'b1);
      check("t5_req_flush", valid, 1'b0);
      check("t5_req_addr",  imem_addr, 64'h200);
      step();
      check("t5_tgt2_pc",    pc, 64'h200);
      check("t5_tgt2_instr", instr, 32'h5A5A_0200);

      // Reset in the middle of a request while pc_F=0x40 is held.
      lat = 3;
      redirect(64'h40, 1'b1);
      stall = 1'b1;
      wait_valid("t6_v40");
      check("t6_pc40", pc, 64'h40);
      step();
      check("t6_held_pc", pc, 64'h40);
      reset = 1'b0;
      #1;
      check("t6_async_req",   imem_req, 1'b0);
      check("t6_async_addr",  imem_addr, 64'h0);
      check("t6_async_instr", instr, 32'h0);
      check("t6_async_pc",    pc, 64'h0);
      check("t6_async_valid", valid, 1'b0);
      lat = 0;
      do_reset();
      step();
      check("t6_restart_addr", imem_addr, 64'h0);
      step();
      check("t6_restart_pc",    pc, 64'h0);
      check("t6_restart_valid", valid, 1'b1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
